// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: turns one valid/ready request at a time into R_W / Ea
// strobes for a bank of storage registers and returns one response per request.
// Optional macro REG_ACCESS_READBACK_EN: after each write, read the register
// back through the bus and flag a mismatch in rsp_err.
//
// Handshake: a request transfers on a rising CLK edge where req_valid and
// req_ready are both 1; a response transfers on an edge where rsp_valid and
// rsp_ready are both 1. rsp_valid stays high with stable fields until then,
// and req_ready is high only while idle.
module reg_access_ctrl #(
    parameter int NREG    = 4,
    parameter int AW      = 2,
    parameter int DW      = 16,
    parameter int RD_WAIT = 1
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic [DW-1:0]   reg_D,
    output logic [NREG-1:0] reg_RW,
    output logic [NREG-1:0] reg_Ea,
    input  logic [DW-1:0]   bus_Qa,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RSP  = 3'd3;
`ifdef REG_ACCESS_READBACK_EN
    localparam logic [2:0] S_VFY  = 3'd4;
`endif

    localparam logic [AW:0] NREG_L  = (AW+1)'(NREG);
    localparam logic [2:0]  WAIT_L  = 3'(RD_WAIT);

    logic [2:0]      state;
    logic [2:0]      cnt;
    logic [DW-1:0]   lat_wdata;
    logic [NREG-1:0] req_sel;
    logic            addr_bad;
`ifdef REG_ACCESS_READBACK_EN
    logic [NREG-1:0] lat_sel;
`endif

    // Decode the request address into a one-hot register select.
    always_comb begin
        req_sel  = NREG'(1) << req_addr;
        addr_bad = ({1'b0, req_addr} >= NREG_L);
    end

    assign req_ready = (state == S_IDLE);
    assign dbg_state = state;

    // Main sequencer: strobes, response fields and wait counter.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_wdata <= '0;
            reg_D     <= '0;
            reg_RW    <= '1;
            reg_Ea    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef REG_ACCESS_READBACK_EN
            lat_sel   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_wdata <= req_wdata;
`ifdef REG_ACCESS_READBACK_EN
                        lat_sel   <= req_sel;
`endif
                        if (addr_bad) begin
                            // No register behind this index: answer at once.
                            state     <= S_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state  <= S_WR;
                            reg_D  <= req_wdata;
                            reg_RW <= ~req_sel;
                        end else begin
                            state  <= S_RD;
                            reg_Ea <= req_sel;
                            cnt    <= WAIT_L;
                        end
                    end
                end
                S_WR: begin
                    // The register captures reg_D on this edge.
                    reg_RW <= '1;
`ifdef REG_ACCESS_READBACK_EN
                    state  <= S_VFY;
                    reg_Ea <= lat_sel;
                    cnt    <= WAIT_L;
`else
                    state     <= S_RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= lat_wdata;
                    rsp_err   <= 1'b0;
`endif
                end
                S_RD: begin
                    if (cnt == 3'd0) begin
                        state     <= S_RSP;
                        reg_Ea    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= bus_Qa;
                        rsp_err   <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
`ifdef REG_ACCESS_READBACK_EN
                S_VFY: begin
                    if (cnt == 3'd0) begin
                        state     <= S_RSP;
                        reg_Ea    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= bus_Qa;
                        rsp_err   <= (bus_Qa != lat_wdata);
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
`endif
                S_RSP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: register-bank model on the bus side, shadow
// array plus expected-response queue as the reference, random and directed
// transactions. Honours REG_ACCESS_READBACK_EN when defined.
`timescale 1ns/1ps
module tb_reg_access_ctrl;
    localparam int NREG    = 4;
    localparam int AW      = 3;
    localparam int DW      = 16;
    localparam int RD_WAIT = 1;
`ifdef REG_ACCESS_READBACK_EN
    localparam int WR_LAT = RD_WAIT + 3;
    localparam int WR_EA  = RD_WAIT + 1;
`else
    localparam int WR_LAT = 2;
    localparam int WR_EA  = 0;
`endif
    localparam int RD_LAT = RD_WAIT + 2;

    logic            CLK;
    logic            CLR;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [DW-1:0]   reg_D;
    logic [NREG-1:0] reg_RW;
    logic [NREG-1:0] reg_Ea;
    logic [DW-1:0]   bus_Qa;
    logic [2:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem    [NREG];
    logic [DW-1:0] shadow [NREG];
    logic [DW-1:0] rb_mask;
    logic [DW:0]   exp_q[$];

    reg_access_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .RD_WAIT(RD_WAIT)) dut (
        .CLK(CLK), .CLR(CLR),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_D(reg_D), .reg_RW(reg_RW), .reg_Ea(reg_Ea),
        .bus_Qa(bus_Qa), .dbg_state(dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register bank: capture on edges where R_W is low.
    always @(posedge CLK) begin
        for (int i = 0; i < NREG; i++)
            if (!reg_RW[i]) mem[i] <= reg_D;
    end

    // Read bus: OR of enabled registers, optionally corrupted by rb_mask.
    always_comb begin
        bus_Qa = '0;
        for (int i = 0; i < NREG; i++)
            if (reg_Ea[i]) bus_Qa = bus_Qa | mem[i];
        if (reg_Ea != '0) bus_Qa = bus_Qa ^ rb_mask;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected response from the access rules and the shadow contents.
    task automatic model_push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (int'(addr) >= NREG) begin
            exp_q.push_back({1'b1, {DW{1'b0}}});
        end else if (we) begin
            exp_q.push_back({(rb_mask != '0), wdata ^ rb_mask});
            shadow[addr] = wdata;
        end else begin
            exp_q.push_back({1'b0, shadow[addr]});
        end
    endtask

    // Driver: one full transaction with optional response back-pressure.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int hold);
        int lat, rw_hit, ea_hit, bad, exp_lat, exp_ea;
        logic [NREG-1:0] sel;
        logic [DW:0] exp;
        logic in_range;
        in_range = (int'(addr) < NREG);
        sel = in_range ? (NREG'(1) << addr) : '0;
        model_push(we, addr, wdata);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_we = 1'($urandom_range(0, 1)); req_addr = AW'($urandom); req_wdata = DW'($urandom);
        lat = 1; rw_hit = 0; ea_hit = 0; bad = 0;
        while (!rsp_valid && lat < 32) begin
            if (reg_RW != '1) begin
                if (in_range && reg_RW == ~sel) rw_hit++; else bad++;
            end
            if (reg_Ea != '0) begin
                if (in_range && reg_Ea == sel) ea_hit++; else bad++;
            end
            if (reg_RW != '1 && reg_Ea != '0) bad++;
            tick();
            lat++;
        end
        if (!in_range) begin exp_lat = 1; exp_ea = 0; end
        else if (we)   begin exp_lat = WR_LAT; exp_ea = WR_EA; end
        else           begin exp_lat = RD_LAT; exp_ea = RD_WAIT + 1; end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rw_cycles", 32'(rw_hit), (in_range && we) ? 32'd1 : 32'd0);
        chk("ea_cycles", 32'(ea_hit), 32'(exp_ea));
        chk("strobe_bad", 32'(bad), 32'd0);
        chk("rsp_strobes_off", 32'({reg_RW, reg_Ea}), 32'({{NREG{1'b1}}, {NREG{1'b0}}}));
        if (in_range && we) chk("reg_D", 32'(reg_D), 32'(wdata));
        exp = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp[DW-1:0]));
        chk("rsp_err", 32'(rsp_err), 32'(exp[DW]));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_we = 1'($urandom_range(0, 1)); req_addr = AW'($urandom); req_wdata = DW'($urandom);
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", 32'(rsp_rdata), 32'(exp[DW-1:0]));
            chk("hold_err", 32'(rsp_err), 32'(exp[DW]));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    // Driver: accept a transaction, then pull reset while it is in flight.
    task automatic cut_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        chk("cut_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        CLR = 1'b0;
        #1;
        chk("cut_rw_async", 32'(reg_RW), 32'({NREG{1'b1}}));
        chk("cut_ea_async", 32'(reg_Ea), 32'd0);
        chk("cut_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) tick();
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cut_no_rsp", 32'(rsp_valid), 32'd0);
            chk("cut_req_ready_after", 32'(req_ready), 32'd1);
        end
    endtask

    // Stimulus sequence
    initial begin
        CLR = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; rb_mask = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_reg_RW", 32'(reg_RW), 32'({NREG{1'b1}}));
        chk("rst_reg_Ea", 32'(reg_Ea), 32'd0);
        chk("rst_reg_D", 32'(reg_D), 32'd0);
        CLR = 1'b1;
        tick();

        for (int i = 0; i < NREG; i++) do_txn(1'b1, AW'(i), DW'($urandom), 0);

        do_txn(1'b1, 3'd2, 16'hA5C3, 0);
        do_txn(1'b0, 3'd2, 16'h0000, 0);
        do_txn(1'b0, 3'd5, 16'hFFFF, 0);
        do_txn(1'b1, 3'd7, 16'h1111, 0);
        do_txn(1'b0, 3'd1, 16'h0000, 5);
        do_txn(1'b1, 3'd3, 16'h5A5A, 0);

        cut_txn(1'b1, 3'd1, 16'hDEAD);
        do_txn(1'b0, 3'd1, 16'h0000, 0);
        cut_txn(1'b0, 3'd2, 16'h0000);
        do_txn(1'b0, 3'd2, 16'h0000, 0);

`ifdef REG_ACCESS_READBACK_EN
        rb_mask = 16'h0004;
        do_txn(1'b1, 3'd0, 16'h1234, 0);
        rb_mask = '0;
        do_txn(1'b1, 3'd0, 16'h1234, 0);
`endif

        repeat (40) do_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                           DW'($urandom), $urandom_range(0, 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
